// File: rtl/drp_reconf_master_if.sv
// Request/status and DRP bus bundle for drp_reconf_master.
// master = the reconfiguration block, slave = requester plus DRP responder.
interface drp_reconf_master_if;
   logic        START;
   logic        RD_ONLY;
   logic [6:0]  REQ_ADDR;
   logic [15:0] REQ_MASK;
   logic [15:0] REQ_DATA;
   logic        BUSY;
   logic        DONE;
   logic        ERROR;
   logic [15:0] RDATA;
   logic [6:0]  DADDR;
   logic        DEN;
   logic        DWE;
   logic [15:0] DI;
   logic [15:0] DO;
   logic        DRDY;

   modport master (
      input  START, RD_ONLY, REQ_ADDR, REQ_MASK, REQ_DATA, DO, DRDY,
      output BUSY, DONE, ERROR, RDATA, DADDR, DEN, DWE, DI
   );

   modport slave (
      output START, RD_ONLY, REQ_ADDR, REQ_MASK, REQ_DATA, DO, DRDY,
      input  BUSY, DONE, ERROR, RDATA, DADDR, DEN, DWE, DI
   );
endinterface

// File: rtl/drp_reconf_master.sv
// DRP read / read-modify-write master with DRDY timeout; START->DONE in 3 (read) or 5 (RMW) cycles minimum.
// No backpressure: START is accepted only in IDLE and dropped while BUSY.
module drp_reconf_master #(
   parameter int TIMEOUT = 64
) (
   input logic                 DCLK,
   input logic                 RST,
   drp_reconf_master_if.master bus
);
   typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, FIN} state_t;

   // Counter value of the last permitted wait cycle; DRDY in that cycle still wins.
   localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

   state_t      state;
   logic        rd_only;
   logic [15:0] mask;
   logic [15:0] data;
   logic [15:0] cnt;

   always_ff @(posedge DCLK) begin
      if (RST) begin
         state     <= IDLE;
         rd_only   <= 1'b0;
         mask      <= '0;
         data      <= '0;
         cnt       <= '0;
         bus.BUSY  <= 1'b0;
         bus.DONE  <= 1'b0;
         bus.ERROR <= 1'b0;
         bus.RDATA <= '0;
         bus.DADDR <= '0;
         bus.DEN   <= 1'b0;
         bus.DWE   <= 1'b0;
         bus.DI    <= '0;
      end else begin
         bus.DONE  <= 1'b0;
         bus.ERROR <= 1'b0;
         bus.DEN   <= 1'b0;
         bus.DWE   <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.START) begin
                  rd_only   <= bus.RD_ONLY;
                  mask      <= bus.REQ_MASK;
                  data      <= bus.REQ_DATA;
                  bus.DADDR <= bus.REQ_ADDR;
                  bus.DEN   <= 1'b1;
                  bus.BUSY  <= 1'b1;
                  state     <= RD_REQ;
               end
            end
            RD_REQ: begin
               cnt   <= '0;
               state <= RD_WAIT;
            end
            RD_WAIT: begin
               if (bus.DRDY) begin
                  bus.RDATA <= bus.DO;
                  if (rd_only) begin
                     bus.DONE <= 1'b1;
                     state    <= FIN;
                  end else begin
                     bus.DI  <= (bus.DO & mask) | (data & ~mask);
                     bus.DEN <= 1'b1;
                     bus.DWE <= 1'b1;
                     state   <= WR_REQ;
                  end
               end else if (cnt == CNT_LAST) begin
                  bus.DONE  <= 1'b1;
                  bus.ERROR <= 1'b1;
                  state     <= FIN;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            WR_REQ: begin
               cnt   <= '0;
               state <= WR_WAIT;
            end
            WR_WAIT: begin
               if (bus.DRDY) begin
                  bus.DONE <= 1'b1;
                  state    <= FIN;
               end else if (cnt == CNT_LAST) begin
                  bus.DONE  <= 1'b1;
                  bus.ERROR <= 1'b1;
                  state     <= FIN;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            FIN: begin
               bus.BUSY <= 1'b0;
               state    <= IDLE;
            end
            default: begin
               bus.BUSY <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_drp_reconf_master.sv
// Randomized scoreboard bench for drp_reconf_master against a register-file DRP responder model.
module tb_drp_reconf_master;
   localparam int TO    = 8;
   localparam int NEVER = 0;

   logic DCLK;
   logic RST;

   drp_reconf_master_if bus ();

   drp_reconf_master #(.TIMEOUT(TO)) dut (
      .DCLK (DCLK),
      .RST  (RST),
      .bus  (bus)
   );

   typedef struct {
      logic        err;
      logic [15:0] rdata;
      int          wr;
      logic [15:0] di;
      logic [6:0]  addr;
      int          start;
      int          lat;
   } exp_t;

   exp_t        sb[$];
   logic [15:0] dev_mem [128];
   logic [15:0] ref_mem [128];
   logic [15:0] exp_rdata;
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          cur_rd_delay = 1;
   int          cur_wr_delay = 1;
   bit          stray = 0;

   initial begin
      DCLK = 1'b0;
      forever #5 DCLK = ~DCLK;
   end

   initial forever begin
      @(posedge DCLK);
      cyc++;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // DRP responder: DRDY arrives d cycles after the DEN cycle (d = 0 means never).
   initial begin
      int          pend;
      logic [6:0]  p_addr;
      logic        p_we;
      logic [15:0] p_di;
      int          d;
      pend = 0;
      bus.DRDY = 1'b0;
      bus.DO = '0;
      forever begin
         @(negedge DCLK);
         bus.DRDY = 1'b0;
         bus.DO = 16'($urandom);
         if (RST) begin
            pend = 0;
         end else begin
            if (pend > 0) begin
               pend--;
               if (pend == 0) begin
                  bus.DRDY = 1'b1;
                  if (p_we) dev_mem[p_addr] = p_di;
                  else      bus.DO = dev_mem[p_addr];
               end
            end else if (stray) begin
               bus.DRDY = 1'b1;
               stray = 0;
            end
            if (bus.DEN && pend == 0) begin
               p_addr = bus.DADDR;
               p_we   = bus.DWE;
               p_di   = bus.DI;
               d      = bus.DWE ? cur_wr_delay : cur_rd_delay;
               pend   = d;
            end
         end
      end
   end

   // Monitor: pops the scoreboard whenever DONE is presented.
   initial begin
      int          rd_seen, wr_seen;
      logic [15:0] w_di;
      logic [6:0]  w_addr;
      logic        prev_den, prev_done;
      exp_t        e;
      rd_seen = 0; wr_seen = 0; w_di = '0; w_addr = '0;
      prev_den = 1'b0; prev_done = 1'b0;
      forever begin
         @(negedge DCLK);
         if (RST) begin
            rd_seen = 0;
            wr_seen = 0;
         end else begin
            if (bus.DEN) begin
               chk("den_single_cycle", 32'(prev_den), 32'd0);
               if (bus.DWE) begin
                  wr_seen++;
                  w_di   = bus.DI;
                  w_addr = bus.DADDR;
               end else begin
                  rd_seen++;
               end
            end
            if (bus.ERROR) chk("error_with_done", 32'(bus.DONE), 32'd1);
            if (prev_done) chk("busy_after_done", 32'(bus.BUSY), 32'd0);
            if (bus.DONE) begin
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_done: got DONE, expected no transaction in flight");
               end else begin
                  e = sb.pop_front();
                  chk("error_flag", 32'(bus.ERROR), 32'(e.err));
                  chk("rdata", 32'(bus.RDATA), 32'(e.rdata));
                  chk("write_count", 32'(wr_seen), 32'(e.wr));
                  chk("read_count", 32'(rd_seen), 32'd1);
                  chk("busy_at_done", 32'(bus.BUSY), 32'd1);
                  chk("daddr_held", 32'(bus.DADDR), 32'(e.addr));
                  if (e.wr == 1) begin
                     chk("write_di", 32'(w_di), 32'(e.di));
                     chk("write_addr", 32'(w_addr), 32'(e.addr));
                  end
                  if (e.lat > 0) chk("latency", 32'(cyc - e.start), 32'(e.lat));
               end
               rd_seen = 0;
               wr_seen = 0;
            end
         end
         prev_den  = bus.DEN;
         prev_done = bus.DONE;
      end
   end

   task automatic wait_idle();
      int n = 0;
      while (bus.BUSY !== 1'b0 && n < 100) begin
         @(negedge DCLK);
         n++;
      end
      if (n >= 100) chk("idle_timeout", 32'(bus.BUSY), 32'd0);
   endtask

   task automatic set_mem(input logic [6:0] a, input logic [15:0] v);
      dev_mem[a] = v;
      ref_mem[a] = v;
   endtask

   task automatic issue(input bit rdo, input logic [6:0] a, input logic [15:0] m,
                        input logic [15:0] d, input int rdl, input int wrl,
                        input bit push, input bit hold);
      exp_t        e;
      logic [15:0] old;
      int          n;
      wait_idle();
      cur_rd_delay = rdl;
      cur_wr_delay = wrl;
      e.addr = a; e.start = cyc; e.lat = 0; e.wr = 0; e.di = '0; e.err = 1'b0;
      e.rdata = exp_rdata;
      if (rdl == NEVER) begin
         e.err = 1'b1;
      end else begin
         old     = ref_mem[a];
         e.rdata = old;
         if (rdo) begin
            e.lat = rdl + 2;
         end else begin
            e.di = (old & m) | (d & ~m);
            e.wr = 1;
            if (wrl == NEVER) e.err = 1'b1;
            else              e.lat = rdl + wrl + 3;
         end
      end
      if (push) begin
         exp_rdata = e.rdata;
         if (e.wr == 1 && !e.err) ref_mem[a] = e.di;
         sb.push_back(e);
      end
      bus.START = 1'b1; bus.RD_ONLY = rdo; bus.REQ_ADDR = a; bus.REQ_MASK = m; bus.REQ_DATA = d;
      @(negedge DCLK);
      if (hold) begin
         n = 0;
         while (!bus.DONE && n < 64) begin
            bus.RD_ONLY = 1'($urandom); bus.REQ_ADDR = 7'($urandom);
            bus.REQ_MASK = 16'($urandom); bus.REQ_DATA = 16'($urandom);
            @(negedge DCLK);
            n++;
         end
         if (n >= 64) chk("hold_done_timeout", 32'(bus.DONE), 32'd1);
         @(negedge DCLK);
      end
      bus.START = 1'b0;
   endtask

   initial begin
      int n;
      for (int i = 0; i < 128; i++) set_mem(7'(i), 16'($urandom));
      exp_rdata = '0;
      bus.START = 1'b1; bus.RD_ONLY = 1'b0; bus.REQ_ADDR = 7'h55;
      bus.REQ_MASK = '0; bus.REQ_DATA = 16'hFFFF;
      RST = 1'b1;
      repeat (3) @(negedge DCLK);
      chk("reset_busy", 32'(bus.BUSY), 32'd0);
      chk("reset_done", 32'(bus.DONE), 32'd0);
      chk("reset_error", 32'(bus.ERROR), 32'd0);
      chk("reset_den", 32'(bus.DEN), 32'd0);
      chk("reset_dwe", 32'(bus.DWE), 32'd0);
      chk("reset_daddr", 32'(bus.DADDR), 32'd0);
      chk("reset_di", 32'(bus.DI), 32'd0);
      chk("reset_rdata", 32'(bus.RDATA), 32'd0);
      bus.START = 1'b0;
      RST = 1'b0;
      @(negedge DCLK);
      chk("start_in_reset_ignored", 32'(bus.BUSY), 32'd0);

      set_mem(7'h08, 16'h1234);
      set_mem(7'h10, 16'hAB00);
      set_mem(7'h16, 16'h00C3);
      issue(1'b0, 7'h08, 16'h0000, 16'h6183, 1, 1, 1'b1, 1'b0);
      issue(1'b0, 7'h10, 16'hFF00, 16'h0083, 1, 1, 1'b1, 1'b0);
      issue(1'b1, 7'h16, 16'h5A5A, 16'hFFFF, 1, 1, 1'b1, 1'b0);
      issue(1'b0, 7'h20, 16'h00FF, 16'h1111, NEVER, 1, 1'b1, 1'b0);
      issue(1'b1, 7'h21, 16'h0000, 16'h0000, TO, 1, 1'b1, 1'b0);
      issue(1'b0, 7'h22, 16'hF0F0, 16'h1234, 2, NEVER, 1'b1, 1'b0);
      issue(1'b0, 7'h23, 16'h0F0F, 16'hBEEF, TO, TO, 1'b1, 1'b0);

      // START held high through the whole transaction, including FIN.
      issue(1'b1, 7'h30, 16'h0000, 16'h0000, 3, 1, 1'b1, 1'b1);
      wait_idle();
      repeat (3) begin
         stray = 1;
         repeat (2) @(negedge DCLK);
      end
      chk("stray_busy", 32'(bus.BUSY), 32'd0);
      chk("stray_rdata", 32'(bus.RDATA), 32'(exp_rdata));
      chk("stray_den", 32'(bus.DEN), 32'd0);

      // Reset while waiting for the write acknowledge.
      issue(1'b0, 7'h40, 16'h0000, 16'hCAFE, 1, 6, 1'b0, 1'b0);
      n = 0;
      while (!(bus.DEN && bus.DWE) && n < 40) begin
         @(negedge DCLK);
         n++;
      end
      chk("rst_test_write_seen", 32'(bus.DEN && bus.DWE), 32'd1);
      @(negedge DCLK);
      RST = 1'b1;
      @(negedge DCLK);
      chk("midrst_busy", 32'(bus.BUSY), 32'd0);
      chk("midrst_done", 32'(bus.DONE), 32'd0);
      chk("midrst_den", 32'(bus.DEN), 32'd0);
      chk("midrst_daddr", 32'(bus.DADDR), 32'd0);
      chk("midrst_di", 32'(bus.DI), 32'd0);
      chk("midrst_rdata", 32'(bus.RDATA), 32'd0);
      @(negedge DCLK);
      RST = 1'b0;
      exp_rdata = '0;
      issue(1'b0, 7'h08, 16'hFF00, 16'h00AA, 1, 1, 1'b1, 1'b0);

      for (int i = 0; i < 40; i++) begin
         int rdl, wrl;
         rdl = ($urandom_range(0, 7) == 0) ? NEVER : int'($urandom_range(1, TO));
         wrl = ($urandom_range(0, 7) == 0) ? NEVER : int'($urandom_range(1, TO));
         issue(1'($urandom), 7'($urandom), 16'($urandom), 16'($urandom), rdl, wrl, 1'b1, 1'b0);
      end

      wait_idle();
      repeat (4) @(negedge DCLK);
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
